// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA config bus: feature codes, address field slicing and
// responder FSM state encoding.
package cgra_cfg_pkg;

  localparam logic [7:0] FEAT_REG  = 8'h00;
  localparam logic [7:0] FEAT_SRAM = 8'h01;

  typedef logic [2:0] cfg_state_e;

  localparam cfg_state_e IDLE    = 3'd0;
  localparam cfg_state_e SRAM_WR = 3'd1;
  localparam cfg_state_e SRAM_RD = 3'd2;
  localparam cfg_state_e RD_WAIT = 3'd3;
  localparam cfg_state_e RD_HOLD = 3'd4;

  function automatic logic [7:0] addr_idx(input logic [31:0] addr);
    return addr[31:24];
  endfunction

  function automatic logic [7:0] addr_feat(input logic [31:0] addr);
    return addr[23:16];
  endfunction

  function automatic logic [15:0] addr_tile(input logic [31:0] addr);
    return addr[15:0];
  endfunction

endpackage

// File: rtl/tile_config_responder_if.sv
// Config bus between the array-level config master and one tile responder.
interface tile_config_responder_if;

  logic [31:0] config_config_addr;
  logic [31:0] config_config_data;
  logic        config_read;
  logic        config_write;
  logic [31:0] read_config_data;

  modport master (
    output config_config_addr,
    output config_config_data,
    output config_read,
    output config_write,
    input  read_config_data
  );

  modport slave (
    input  config_config_addr,
    input  config_config_data,
    input  config_read,
    input  config_write,
    output read_config_data
  );

endinterface

// File: rtl/cfg_addr_decode.sv
// Combinational split of a config address into tile hit, feature code and register index.
module cfg_addr_decode
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned NumRegs = 8
) (
  input  logic [31:0] addr_i,
  input  logic [15:0] tile_id_i,
  output logic        hit_o,
  output logic [7:0]  feature_o,
  output logic [7:0]  idx_o,
  output logic        bad_idx_o
);

  assign hit_o     = (addr_tile(addr_i) == tile_id_i);
  assign feature_o = addr_feat(addr_i);
  assign idx_o     = addr_idx(addr_i);
  assign bad_idx_o = (32'(idx_o) >= NumRegs);

endmodule

// File: rtl/tile_config_responder.sv
// Tile-side config bus responder: owns the config register file, bridges feature-1 accesses
// to the tile SRAM and drives a registered read response that is zero unless addressed.
module tile_config_responder
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned NumRegs   = 8,
  parameter int unsigned SramAw    = 9,
  parameter int unsigned RdTimeout = 16,
  parameter int unsigned FlushBit  = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            tile_id,
  input  logic                   stall,
  tile_config_responder_if.slave cfg,
  output logic [NumRegs*32-1:0]  cfg_regs,
  output logic                   flush,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [SramAw-1:0]      sram_addr,
  output logic [15:0]            sram_wdata,
  input  logic [15:0]            sram_rdata,
  input  logic                   sram_rvalid,
  output logic                   cfg_err
);

  localparam int unsigned IdxW = $clog2(NumRegs);
  localparam int unsigned CntW = $clog2(RdTimeout) + 1;

  logic        hit;
  logic [7:0]  feature;
  logic [7:0]  idx;
  logic        bad_idx;
  logic [IdxW-1:0] idx_sel;
  logic [SramAw-1:0] word;

  cfg_addr_decode #(
    .NumRegs (NumRegs)
  ) u_decode (
    .addr_i    (cfg.config_config_addr),
    .tile_id_i (tile_id),
    .hit_o     (hit),
    .feature_o (feature),
    .idx_o     (idx),
    .bad_idx_o (bad_idx)
  );

  cfg_state_e        state_q, state_d;
  logic [31:0]       regs_q [NumRegs];
  logic [31:0]       regs_d [NumRegs];
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SramAw-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       addr_q, addr_d;
  logic              read_prev_q;

  logic wr_hit, rd_hit, rd_rise;

  assign idx_sel = idx[IdxW-1:0];
  // Each config index owns two SRAM words; the sub-word select lives in reg 1 bit 0.
  assign word    = SramAw'({idx, regs_q[1][0]});
  assign wr_hit  = cfg.config_write & hit;
  assign rd_hit  = cfg.config_read & hit;
  assign rd_rise = rd_hit & ~read_prev_q;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;

    unique case (state_q)
      IDLE: begin
        rdata_d = '0;
        if (wr_hit) begin
          if (cfg.config_read) err_d = 1'b1;
          if (feature == FEAT_REG) begin
            if (bad_idx) err_d = 1'b1;
            else         regs_d[idx_sel] = cfg.config_config_data;
          end else if (feature == FEAT_SRAM) begin
            if (stall) begin
              sram_addr_d = word;
              wdata_d     = cfg.config_config_data[15:0];
              state_d     = SRAM_WR;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (rd_hit) begin
          if (feature == FEAT_REG) begin
            if (bad_idx) err_d = 1'b1;
            else         rdata_d = regs_q[idx_sel];
          end else if (feature == FEAT_SRAM) begin
            if (stall) begin
              sram_addr_d = word;
              addr_d      = cfg.config_config_addr;
              state_d     = SRAM_RD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      SRAM_WR: state_d = IDLE;
      SRAM_RD: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (sram_rvalid) begin
          rdata_d = {16'h0, sram_rdata};
          state_d = RD_HOLD;
        end else if (cnt_q == CntW'(RdTimeout - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RD_HOLD;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RD_HOLD: begin
        if (!cfg.config_read || (cfg.config_config_addr != addr_q)) begin
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The read that started a transaction stays high through it; only fresh strobes are errors.
    if ((state_q != IDLE) && (wr_hit || (rd_rise && (state_q != RD_HOLD)))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      regs_q      <= '{default: '0};
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      sram_addr_q <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      read_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      read_prev_q <= cfg.config_read;
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < NumRegs; i++) cfg_regs[i*32 +: 32] = regs_q[i];
  end

  assign cfg.read_config_data = rdata_q;
  assign flush      = regs_q[0][FlushBit];
  assign sram_req   = (state_q == SRAM_WR) || (state_q == SRAM_RD);
  assign sram_we    = (state_q == SRAM_WR);
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = wdata_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_tile_config_responder.sv
// Directed and randomized checks of tile_config_responder against a register-file model.
module tb_tile_config_responder;

  localparam int unsigned NumRegs   = 8;
  localparam int unsigned RdTimeout = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [15:0]           tile_id;
  logic                  stall;
  logic [NumRegs*32-1:0] cfg_regs;
  logic                  flush, sram_req, sram_we, cfg_err;
  logic [8:0]            sram_addr;
  logic [15:0]           sram_wdata, sram_rdata;
  logic                  sram_rvalid;

  tile_config_responder_if bus ();

  tile_config_responder dut (
    .clk         (clk),
    .reset       (reset),
    .tile_id     (tile_id),
    .stall       (stall),
    .cfg         (bus),
    .cfg_regs    (cfg_regs),
    .flush       (flush),
    .sram_req    (sram_req),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_rvalid (sram_rvalid),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  // SRAM model: fixed 2-cycle read latency after the request cycle; sram_en=0 withholds rvalid.
  logic [15:0] mem [512];
  logic [1:0]  rd_pipe = '0;
  logic [8:0]  rd_addr_q = '0;
  logic        sram_en = 1'b1;

  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[0], sram_req & ~sram_we & sram_en};
    if (sram_req & ~sram_we) rd_addr_q <= sram_addr;
    if (sram_req & sram_we) mem[sram_addr] <= sram_wdata;
  end
  assign sram_rvalid = rd_pipe[1];
  assign sram_rdata  = rd_pipe[1] ? mem[rd_addr_q] : 16'h0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_regs [NumRegs];
  logic        model_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.config_config_addr = addr;
    bus.config_config_data = data;
    bus.config_write       = 1'b1;
    tick();
    bus.config_write       = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.config_config_addr = addr;
    bus.config_read        = 1'b1;
    tick();
    check(tag, bus.read_config_data, exp);
    bus.config_read        = 1'b0;
    tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < NumRegs; i++) model_regs[i] = '0;
    model_err = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NumRegs; i++) check(tag, cfg_regs[i*32 +: 32], model_regs[i]);
    check({tag, "_flush"}, {31'b0, flush}, {31'b0, model_regs[0][9]});
  endtask

  task automatic do_reset_check(input string tag);
    bus.config_read  = 1'b0;
    bus.config_write = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    model_clear();
    check({tag, "_rdata"}, bus.read_config_data, 32'h0);
    check({tag, "_req"}, {31'b0, sram_req}, 32'h0);
    check({tag, "_we"}, {31'b0, sram_we}, 32'h0);
    check({tag, "_saddr"}, {23'b0, sram_addr}, 32'h0);
    check({tag, "_wdata"}, {16'b0, sram_wdata}, 32'h0);
    check({tag, "_err"}, {31'b0, cfg_err}, 32'h0);
    check_regs({tag, "_regs"});
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0]  r_idx, r_feat;
  logic [15:0] r_tile;
  logic [31:0] r_data, r_exp;
  logic        r_hit, r_wr, done;
  int          wait_n;

  initial begin
    reset                  = 1'b0;
    tile_id                = 16'h0102;
    stall                  = 1'b0;
    bus.config_config_addr = '0;
    bus.config_config_data = '0;
    bus.config_read        = 1'b0;
    bus.config_write       = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    do_reset_check("reset0");

    // Register round trip and flush export.
    wr(32'h0000_0102, 32'h001C_7E00);
    model_regs[0] = 32'h001C_7E00;
    check_regs("wr_reg0");
    bus.config_config_addr = 32'h0000_0102;
    bus.config_read        = 1'b1;
    #1;
    check("rd_registered", bus.read_config_data, 32'h0);
    tick();
    check("rd_reg0", bus.read_config_data, 32'h001C_7E00);
    bus.config_read = 1'b0;
    tick();
    check("rd_idle_zero", bus.read_config_data, 32'h0);
    wr(32'h0000_0102, 32'h001C_0000);
    model_regs[0] = 32'h001C_0000;
    check_regs("flush_clear");

    // Miss: another tile's address.
    wr(32'h0000_0205, 32'hDEAD_BEEF);
    check_regs("miss_wr");
    rd_check("miss_rd", 32'h0000_0205, 32'h0);
    check("miss_err", {31'b0, cfg_err}, 32'h0);

    // SRAM prefill while stalled.
    stall = 1'b1;
    wr(32'h0501_0102, 32'h0000_0099);
    check("sw_req", {31'b0, sram_req}, 32'h1);
    check("sw_we", {31'b0, sram_we}, 32'h1);
    check("sw_addr", {23'b0, sram_addr}, 32'h0A);
    check("sw_wdata", {16'b0, sram_wdata}, 32'h0099);
    tick();
    check("sw_one_req", {31'b0, sram_req}, 32'h0);

    // SRAM readback.
    bus.config_config_addr = 32'h0501_0102;
    bus.config_read        = 1'b1;
    tick();
    check("sr_req", {31'b0, sram_req}, 32'h1);
    check("sr_we", {31'b0, sram_we}, 32'h0);
    check("sr_addr", {23'b0, sram_addr}, 32'h0A);
    done   = 1'b0;
    wait_n = 1;
    for (int k = 0; k < 6 && !done; k++) begin
      tick();
      wait_n++;
      if (bus.read_config_data != 32'h0) done = 1'b1;
    end
    check("sr_latency_ok", {31'b0, done && (wait_n <= 5)}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      check("sr_hold", bus.read_config_data, 32'h0000_0099);
      tick();
    end
    bus.config_read = 1'b0;
    tick();
    check("sr_drop", bus.read_config_data, 32'h0);
    check("sr_err", {31'b0, cfg_err}, 32'h0);

    // Feature 1 while not stalled.
    stall = 1'b0;
    wr(32'h0501_0102, 32'h0000_1234);
    check("ns_req", {31'b0, sram_req}, 32'h0);
    check("ns_err", {31'b0, cfg_err}, 32'h1);
    rd_check("ns_rd", 32'h0501_0102, 32'h0);

    // Read timeout with no rvalid.
    do_reset_check("reset1");
    stall   = 1'b1;
    sram_en = 1'b0;
    bus.config_config_addr = 32'h0301_0102;
    bus.config_read        = 1'b1;
    done   = 1'b0;
    wait_n = 0;
    for (int k = 1; k <= RdTimeout + 4 && !done; k++) begin
      tick();
      if (cfg_err) begin
        done   = 1'b1;
        wait_n = k;
      end
    end
    check("to_window", {31'b0, done && wait_n >= RdTimeout + 1 && wait_n <= RdTimeout + 3},
          32'h1);
    check("to_rdata", bus.read_config_data, 32'h0);
    tick();
    check("to_hold", bus.read_config_data, 32'h0);
    bus.config_read = 1'b0;
    tick();
    sram_en = 1'b1;
    wr(32'h0300_0102, 32'h1357_9BDF);
    model_regs[3] = 32'h1357_9BDF;
    check_regs("to_idle_wr");
    rd_check("to_idle_rd", 32'h0300_0102, 32'h1357_9BDF);

    // Read and write in the same cycle.
    do_reset_check("reset2");
    bus.config_config_addr = 32'h0200_0102;
    bus.config_config_data = 32'hA5A5_0F0F;
    bus.config_read        = 1'b1;
    bus.config_write       = 1'b1;
    tick();
    bus.config_read  = 1'b0;
    bus.config_write = 1'b0;
    model_regs[2] = 32'hA5A5_0F0F;
    check_regs("col_regs");
    check("col_rdata", bus.read_config_data, 32'h0);
    check("col_err", {31'b0, cfg_err}, 32'h1);

    // Reset during RD_WAIT; the rvalid that follows must be ignored.
    do_reset_check("reset3");
    stall = 1'b1;
    bus.config_config_addr = 32'h0501_0102;
    bus.config_read        = 1'b1;
    tick();
    tick();
    bus.config_read = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_rdata", bus.read_config_data, 32'h0);
    check("mid_rst_req", {31'b0, sram_req}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("late_rvalid_rdata", bus.read_config_data, 32'h0);
    end
    check("late_rvalid_err", {31'b0, cfg_err}, 32'h0);

    // Randomized register traffic against the model.
    do_reset_check("reset4");
    for (int n = 0; n < 80; n++) begin
      r_idx  = 8'($urandom_range(0, NumRegs + 1));
      r_feat = ($urandom_range(0, 5) == 0) ? 8'h02 : 8'h00;
      r_hit  = ($urandom_range(0, 4) != 0);
      r_tile = r_hit ? tile_id : (tile_id ^ 16'($urandom_range(1, 65535)));
      r_data = $urandom;
      r_wr   = $urandom_range(0, 1) == 1;
      stall  = $urandom_range(0, 1) == 1;
      if (r_wr) begin
        wr({r_idx, r_feat, r_tile}, r_data);
        if (r_hit && r_feat == 8'h00) begin
          if (r_idx < NumRegs) model_regs[r_idx[2:0]] = r_data;
          else                 model_err = 1'b1;
        end
      end else begin
        r_exp = (r_hit && r_feat == 8'h00 && r_idx < NumRegs) ? model_regs[r_idx[2:0]] : 32'h0;
        if (r_hit && r_feat == 8'h00 && r_idx >= NumRegs) model_err = 1'b1;
        rd_check("rnd_rd", {r_idx, r_feat, r_tile}, r_exp);
      end
      check_regs("rnd_regs");
      check("rnd_err", {31'b0, cfg_err}, {31'b0, model_err});
      check("rnd_req", {31'b0, sram_req}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
